mem_responder: RTL and testbench

- Word-addressed synchronous RAM slave on the memory side of the MAR/MDR path.
- Accepts one read or write request at a time from the datapath control unit.
- Inserts a programmable access latency, then pulses Done.
- Read data goes to the MDR's memory-data input; write data comes from the MDR register output.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ram_array.sv | 52 +++++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the memory path.
//   DATA_W      : datapath word width
//   mem_state_t : memory responder FSM states (IDLE, BUSY, DONE)
//   mem_op_t    : latched access type (OP_READ, OP_WRITE)
package cpu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous DEPTH x DATA_W word array.
// Ports:
//   clk     : clock, all updates on the rising edge
//   rst_n   : async active-low reset, clears only the read register (not the array)
//   i_we    : write enable, ignored for addresses >= DEPTH
//   i_re    : read enable, loads o_rdata (0 for addresses >= DEPTH)
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data, holds its value while i_re is low
module ram_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned    IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_hit;
    logic [IdxW-1:0]   w_idx;

    assign w_hit = ({1'b0, i_addr} < DepthLim);
    assign w_idx = i_addr[IdxW-1:0];

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we && w_hit) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_hit ? r_mem[w_idx] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM slave on the memory side of the MAR/MDR path.
// Accepts one read or write at a time, waits WAIT_CYCLES busy cycles, then pulses Done.
// Optional macro MEM_ADDR_CHECK_EN: adds AddrErr, flagging out-of-range accesses with Done.
// Ports:
//   clk      : clock
//   Clear_n  : async active-low reset
//   Read     : read request, sampled in IDLE only
//   Write    : write request, sampled in IDLE only (wins over Read)
//   Address  : word address, captured at acceptance
//   MDataOut : write data from the MDR, captured at acceptance
//   MDataIn  : read data toward the MDR mux, valid with Done and held until the next read
//   Done     : one-cycle completion pulse
//   Busy     : high while a request is in flight (BUSY or DONE)
//   AddrErr  : (MEM_ADDR_CHECK_EN only) out-of-range flag, coincident with Done
module mem_responder #(
    parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              Clear_n,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] MDataOut,
    output logic [DATA_W-1:0] MDataIn,
    output logic              Done,
    output logic              Busy
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic              AddrErr
`endif
);

    import cpu_pkg::*;

    localparam int unsigned     CntW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] WaitLoad = CntW'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    mem_state_t        r_state;
    logic [CntW-1:0]   r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    mem_op_t           r_op;

    mem_state_t        w_state_d;
    logic [CntW-1:0]   w_cnt_d;
    logic              w_enter_done;
    logic              w_req;
    mem_op_t           w_req_op;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    mem_op_t           w_sel_op;
    logic              w_in_range;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_rdata;

    assign w_req    = Read | Write;
    assign w_req_op = Write ? OP_WRITE : OP_READ;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_cnt_d = WaitLoad;
                    if (WAIT_CYCLES == 0) begin
                        w_state_d    = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                w_cnt_d = r_cnt - CntW'(1);
                if (r_cnt == CntW'(1)) begin
                    w_state_d    = DONE;
                    w_enter_done = 1'b1;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_op    <= OP_READ;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (r_state == IDLE && w_req) begin
                r_addr <= Address;
                r_data <= MDataOut;
                r_op   <= w_req_op;
            end
        end
    end

    // With zero wait the RAM access happens on the accepting edge itself, so the live
    // request is used; otherwise the access is driven from the latched copy.
    assign w_sel_addr = (r_state == IDLE) ? Address  : r_addr;
    assign w_sel_data = (r_state == IDLE) ? MDataOut : r_data;
    assign w_sel_op   = (r_state == IDLE) ? w_req_op : r_op;
    assign w_in_range = ({1'b0, w_sel_addr} < DepthLim);

    assign w_ram_we = w_enter_done && (w_sel_op == OP_WRITE) && w_in_range;
`ifdef MEM_ADDR_CHECK_EN
    // Out-of-range reads leave MDataIn untouched.
    assign w_ram_re = w_enter_done && (w_sel_op == OP_READ) && w_in_range;
`else
    // Out-of-range reads load zero from the array.
    assign w_ram_re = w_enter_done && (w_sel_op == OP_READ);
`endif

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (Clear_n),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_sel_addr),
        .i_wdata (w_sel_data),
        .o_rdata (w_rdata)
    );

    assign MDataIn = w_rdata;
    assign Done    = (r_state == DONE);
    assign Busy    = (r_state != IDLE);

`ifdef MEM_ADDR_CHECK_EN
    // r_addr always holds the in-flight address by the time DONE is reached.
    assign AddrErr = (r_state == DONE) && !({1'b0, r_addr} < DepthLim);
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// DUT 0: defaults (WAIT_CYCLES=2, DEPTH=512). DUT 1: WAIT_CYCLES=0, DEPTH=400.
// Honours MEM_ADDR_CHECK_EN when defined (AddrErr port and out-of-range read behaviour).
module tb_mem_responder;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit AddrChk = 1'b1;
`else
    localparam bit AddrChk = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clear_n;
    logic        rd     [2];
    logic        wr     [2];
    logic [8:0]  addr   [2];
    logic [31:0] wdat   [2];
    logic [31:0] mdin   [2];
    logic        done   [2];
    logic        busy   [2];
`ifdef MEM_ADDR_CHECK_EN
    logic        aerr_s [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: plain arrays of word contents per DUT.
    logic [31:0] m_mem   [2][512];
    bit          m_known [2][512];
    logic [31:0] m_last  [2];
    int          m_depth [2] = '{512, 400};
    int          m_wait  [2] = '{2, 0};

    always #5 clk = ~clk;

    mem_responder u_dut_a (
        .clk      (clk),
        .Clear_n  (clear_n),
        .Read     (rd[0]),
        .Write    (wr[0]),
        .Address  (addr[0]),
        .MDataOut (wdat[0]),
        .MDataIn  (mdin[0]),
        .Done     (done[0]),
        .Busy     (busy[0])
`ifdef MEM_ADDR_CHECK_EN
        ,
        .AddrErr  (aerr_s[0])
`endif
    );

    mem_responder #(
        .DEPTH       (400),
        .WAIT_CYCLES (0)
    ) u_dut_b (
        .clk      (clk),
        .Clear_n  (clear_n),
        .Read     (rd[1]),
        .Write    (wr[1]),
        .Address  (addr[1]),
        .MDataOut (wdat[1]),
        .MDataIn  (mdin[1]),
        .Done     (done[1]),
        .Busy     (busy[1])
`ifdef MEM_ADDR_CHECK_EN
        ,
        .AddrErr  (aerr_s[1])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_exp_rd(input int d, input bit w, input logic [8:0] a);
        if (w) return m_last[d];
        if (int'(a) < m_depth[d]) return m_mem[d][a];
        return AddrChk ? m_last[d] : 32'h0;
    endfunction

    task automatic model_update(input int d, input bit w, input logic [8:0] a,
                                input logic [31:0] wd);
        if (w) begin
            if (int'(a) < m_depth[d]) begin
                m_mem[d][a]   = wd;
                m_known[d][a] = 1'b1;
            end
        end else begin
            m_last[d] = model_exp_rd(d, 1'b0, a);
        end
    endtask

    // One full transaction: present the request, count edges from acceptance to Done,
    // check data, latency, pulse width and (if present) AddrErr, then update the model.
    task automatic run(input int d, input bit w, input bit r, input logic [8:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
        int lat;
        @(negedge clk);
        rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = wd;
        @(posedge clk);
        #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        lat = 0;
        while (!done[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency d%0d a%0d", d, a), lat, m_wait[d]);
        check($sformatf("mdatain d%0d a%0d", d, a), mdin[d], exp_rd);
`ifdef MEM_ADDR_CHECK_EN
        check($sformatf("addrerr d%0d a%0d", d, a), {31'b0, aerr_s[d]},
              {31'b0, int'(a) >= m_depth[d]});
`endif
        @(posedge clk);
        #1;
        check($sformatf("done_pulse_end d%0d", d), {31'b0, done[d]}, 32'h0);
        check($sformatf("busy_end d%0d", d), {31'b0, busy[d]}, 32'h0);
        model_update(d, w, a, wd);
    endtask

    typedef struct {
        int          d;
        bit          w;
        bit          r;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vec [12];

    initial begin
        logic [31:0] oor;
        logic [31:0] held;
        int          pulses;

        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] oor;
        logic [31:0] held;
        int          pulses;

        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
            m_last[d] = '0;
            for (int i = 0; i < 512; i++) begin
                m_known[d][i] = 1'b0;
                m_mem[d][i]   = '0;
            end
        end
        clear_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset done d%0d", d), {31'b0, done[d]}, 32'h0);
            check($sformatf("reset busy d%0d", d), {31'b0, busy[d]}, 32'h0);
            check($sformatf("reset mdatain d%0d", d), mdin[d], 32'h0);
        end
        clear_n = 1'b1;

        // Reset in the middle of a write aborts it.
        run(0, 1'b1, 1'b0, 9'd5, 32'h11111111, m_last[0]);
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 9'd5; wdat[0] = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        check("abort busy_before", {31'b0, busy[0]}, 32'h1);
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        check("abort done", {31'b0, done[0]}, 32'h0);
        check("abort busy", {31'b0, busy[0]}, 32'h0);
        check("abort mdatain", mdin[0], 32'h0);
        m_last[0] = '0;
        m_last[1] = '0;
        @(negedge clk);
        clear_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort no_busy_after", {31'b0, busy[0]}, 32'h0);
        run(0, 1'b0, 1'b1, 9'd5, 32'h0, 32'h11111111);

        // Directed vectors.
        oor = AddrChk ? 32'h0BADF00D : 32'h0;
        vec[0]  = '{1, 1'b1, 1'b0, 9'd3,   32'hA5A5A5A5, 32'h0};
        vec[1]  = '{1, 1'b0, 1'b1, 9'd3,   32'h0,        32'hA5A5A5A5};
        vec[2]  = '{1, 1'b1, 1'b1, 9'd7,   32'h00000055, 32'hA5A5A5A5};
        vec[3]  = '{1, 1'b0, 1'b1, 9'd7,   32'h0,        32'h00000055};
        vec[4]  = '{1, 1'b1, 1'b0, 9'd399, 32'h0BADF00D, 32'h00000055};
        vec[5]  = '{1, 1'b0, 1'b1, 9'd399, 32'h0,        32'h0BADF00D};
        vec[6]  = '{1, 1'b1, 1'b0, 9'd400, 32'hDEADBEEF, 32'h0BADF00D};
        vec[7]  = '{1, 1'b0, 1'b1, 9'd400, 32'h0,        oor};
        vec[8]  = '{1, 1'b1, 1'b0, 9'd450, 32'h000000FF, oor};
        vec[9]  = '{1, 1'b0, 1'b1, 9'd450, 32'h0,        oor};
        vec[10] = '{0, 1'b1, 1'b0, 9'd10,  32'h12345678, 32'h11111111};
        vec[11] = '{0, 1'b0, 1'b1, 9'd10,  32'h0,        32'h12345678};
        for (int i = 0; i < 12; i++) begin
            run(vec[i].d, vec[i].w, vec[i].r, vec[i].a, vec[i].wd, vec[i].exp_rd);
        end

        // Read pulsed during BUSY is ignored.
        run(0, 1'b1, 1'b0, 9'd20, 32'h20202020, m_last[0]);
        held = m_last[0];
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 9'd4; wdat[0] = 32'h00000044;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 9'd20;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done[0]) pulses++;
        end
        check("busy_req done_pulses", pulses, 1);
        check("busy_req mdatain_held", mdin[0], held);
        model_update(0, 1'b1, 9'd4, 32'h00000044);
        run(0, 1'b0, 1'b1, 9'd4, 32'h0, model_exp_rd(0, 1'b0, 9'd4));

        // Randomised traffic against the model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [8:0]  a;
                logic [31:0] wd;
                int          op;
                bit          w;
                bit          r;
                a  = (d == 0) ? 9'(100 + $urandom_range(0, 15)) : 9'($urandom_range(390, 410));
                wd = $urandom;
                op = $urandom_range(0, 2);
                w  = (op != 0);
                r  = (op != 1);
                if (!w && int'(a) < m_depth[d] && !m_known[d][a]) begin
                    w = 1'b1;
                end
                run(d, w, r, a, wd, model_exp_rd(d, w, a));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
